// File: rtl/alu_mdu_pkg.sv
// Shared types and decode constants for the alu_mdu execute unit.
// Also carries the R_TYPE/I_TYPE major opcodes so every file decodes from one place.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } alu_state_t;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

endpackage

// File: rtl/alu_mdu_divider.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// with sign fix-up and the divide-by-zero / signed-overflow results applied at the end.
module alu_divider
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            is_signed,
    input  logic            want_rem,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0] count;
    logic [XLEN:0]    rem;
    logic [XLEN-1:0]  quot;
    logic [XLEN-1:0]  divisor;
    logic [XLEN-1:0]  dividend_raw;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic             overflow;
    logic             rem_sel;

    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    diff;
    logic [XLEN:0]    rem_next;
    logic [XLEN-1:0]  quot_next;
    logic [XLEN-1:0]  q_final;
    logic [XLEN-1:0]  r_final;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    always_comb begin
        rem_shift = {rem[XLEN-1:0], quot[XLEN-1]};
        diff      = rem_shift - {1'b0, divisor};
        if (!diff[XLEN]) begin
            rem_next  = diff;
            quot_next = {quot[XLEN-2:0], 1'b1};
        end else begin
            rem_next  = rem_shift;
            quot_next = {quot[XLEN-2:0], 1'b0};
        end
    end

    // The final step's result is exposed combinationally so the top registers it on the same edge.
    always_comb begin
        q_final = neg_q ? -quot_next : quot_next;
        r_final = neg_r ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
        if (div_zero) begin
            q_final = '1;
            r_final = dividend_raw;
        end else if (overflow) begin
            q_final = dividend_raw;
            r_final = '0;
        end
        result = rem_sel ? r_final : q_final;
        done   = (count == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            rem          <= '0;
            quot         <= '0;
            divisor      <= '0;
            dividend_raw <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_zero     <= 1'b0;
            overflow     <= 1'b0;
            rem_sel      <= 1'b0;
        end else if (start) begin
            count        <= CNT_W'(XLEN);
            rem          <= '0;
            quot         <= magnitude(a, is_signed);
            divisor      <= magnitude(b, is_signed);
            dividend_raw <= a;
            neg_q        <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r        <= is_signed && a[XLEN-1];
            div_zero     <= (b == '0);
            overflow     <= is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
            rem_sel      <= want_rem;
        end else if (count != '0) begin
            count <= count - 1'b1;
            rem   <= rem_next;
            quot  <= quot_next;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Registered RV32I/RV64I ALU plus M-extension with valid/ready on both sides.
// Build option ALU_MDU_FAST_MUL_EN swaps the iterative multiplier for a single-cycle one.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam int CNT_W   = SHAMT_W + 1;

    alu_state_t       state;
    alu_state_t       state_next;
    alu_state_t       accept_state;
    logic             accept;
    logic             legal;
    logic             is_mext;
    logic             is_div;
    logic [11:0]      shift_field;
    logic [XLEN-1:0]  op2;
    logic [SHAMT_W-1:0] shamt;
    logic             arith;
    logic [XLEN-1:0]  alu_value;
    logic [CNT_W-1:0] counter;
    logic             mul_a_signed;
    logic             mul_b_signed;
    logic             div_done;
    logic [XLEN-1:0]  div_result;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    assign accept = in_valid && in_ready;

    // Shift immediates must leave the bits above the shift amount clear, except imm[10] for SRAI.
    always_comb begin
        shift_field = imm[11:0];
        shift_field[SHAMT_W-1:0] = '0;
        if (func3 == F3_SRL) shift_field[10] = 1'b0;
        legal   = 1'b0;
        is_mext = 1'b0;
        case (opcode)
            R_TYPE: begin
                case (func7)
                    F7_BASE: legal = 1'b1;
                    F7_ALT:  legal = (func3 == F3_ADD) || (func3 == F3_SRL);
                    F7_MEXT: begin
                        legal   = 1'b1;
                        is_mext = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            I_TYPE: legal = ((func3 == F3_SLL) || (func3 == F3_SRL)) ? (shift_field == '0) : 1'b1;
            default: legal = 1'b0;
        endcase
        is_div       = is_mext && func3[2];
        mul_a_signed = (func3 != F3_MULHU);
        mul_b_signed = (func3 == F3_MUL) || (func3 == F3_MULH);
    end

    always_comb begin
        op2       = (opcode == I_TYPE) ? imm : b;
        shamt     = op2[SHAMT_W-1:0];
        arith     = (opcode == I_TYPE) ? imm[10] : func7[5];
        alu_value = '0;
        if (legal && !is_mext) begin
            case (func3)
                F3_ADD:  alu_value = (opcode == R_TYPE && func7 == F7_ALT) ? a - op2 : a + op2;
                F3_SLL:  alu_value = a << shamt;
                F3_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(op2))};
                F3_SLTU: alu_value = {{(XLEN-1){1'b0}}, (a < op2)};
                F3_XOR:  alu_value = a ^ op2;
                F3_SRL:  alu_value = arith ? $unsigned($signed(a) >>> shamt) : a >> shamt;
                F3_OR:   alu_value = a | op2;
                F3_AND:  alu_value = a & op2;
                default: alu_value = '0;
            endcase
        end
    end

`ifdef ALU_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_product;
    logic [XLEN-1:0]   fast_mul_value;

    always_comb begin
        fast_product   = {{XLEN{mul_a_signed && a[XLEN-1]}}, a} * {{XLEN{mul_b_signed && b[XLEN-1]}}, b};
        fast_mul_value = (func3 == F3_MUL) ? fast_product[XLEN-1:0] : fast_product[2*XLEN-1:XLEN];
    end
`else
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_next;
    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   mul_value;
    logic              mul_neg;
    logic [2:0]        func3_q;

    // Shift-add on magnitudes; the last step's sum is sign-corrected before it is registered.
    always_comb begin
        prod_next = prod + (mplier[0] ? mcand : '0);
        mul_full  = mul_neg ? -prod_next : prod_next;
        mul_value = (func3_q == F3_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end
`endif

    alu_divider #(
        .XLEN(XLEN)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && is_div),
        .a         (a),
        .b         (b),
        .is_signed (!func3[0]),
        .want_rem  (func3[1]),
        .done      (div_done),
        .result    (div_result)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        accept_state = DONE;
        if (is_div) begin
            accept_state = DIV;
        end else if (is_mext) begin
`ifdef ALU_MDU_FAST_MUL_EN
            accept_state = DONE;
`else
            accept_state = MUL;
`endif
        end
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = accept_state;
            MUL:     if (counter == CNT_W'(1)) state_next = DONE;
            DIV:     if (div_done) state_next = DONE;
            DONE:    if (out_ready) state_next = accept ? accept_state : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == DONE);
        busy      = (state == MUL) || (state == DIV);
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            counter <= '0;
`ifndef ALU_MDU_FAST_MUL_EN
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            mul_neg <= 1'b0;
            func3_q <= '0;
`endif
        end else if (accept) begin
            if (is_div) begin
                counter <= CNT_W'(XLEN);
            end else if (is_mext) begin
`ifdef ALU_MDU_FAST_MUL_EN
                result  <= fast_mul_value;
`else
                counter <= CNT_W'(XLEN);
                func3_q <= func3;
                mcand   <= {{XLEN{1'b0}}, magnitude(a, mul_a_signed)};
                mplier  <= magnitude(b, mul_b_signed);
                prod    <= '0;
                mul_neg <= (mul_a_signed && a[XLEN-1]) ^ (mul_b_signed && b[XLEN-1]);
`endif
            end else begin
                result <= alu_value;
            end
        end else if (state == MUL) begin
`ifdef ALU_MDU_FAST_MUL_EN
            counter <= '0;
`else
            counter <= counter - 1'b1;
            prod    <= prod_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            if (counter == CNT_W'(1)) result <= mul_value;
`endif
        end else if (state == DIV) begin
            counter <= counter - 1'b1;
            if (div_done) result <= div_result;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed, table-driven bench for alu_mdu at XLEN=32 with hand-written handshake/reset sequences.
// Define ALU_MDU_FAST_MUL_EN for both RTL and bench to expect single-cycle multiplies.
module tb_alu_mdu;
    import alu_pkg::*;

`ifdef ALU_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  func3 = '0;
    logic [6:0]  func7 = '0;
    logic [31:0] imm = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string       name;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_mdu #(
        .XLEN(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .func3     (func3),
        .func7     (func7),
        .imm       (imm),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic void add_vec(input string name, input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] im, input logic [31:0] va,
                                    input logic [31:0] vb, input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = name; v.opcode = op; v.func3 = f3; v.func7 = f7; v.imm = im;
        v.a = va; v.b = vb; v.expected = exp; v.lat = lat;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] im, input logic [31:0] va, input logic [31:0] vb);
        opcode = op; func3 = f3; func7 = f7; imm = im; a = va; b = vb;
        in_valid = 1'b1;
    endtask

    // Issue one op from IDLE, scramble the inputs after accept, then time and check the result.
    task automatic apply_stimulus(input vec_t v);
        int lat;
        int busy_cycles;
        @(negedge clk);
        out_ready = 1'b0;
        drive(v.opcode, v.func3, v.func7, v.imm, v.a, v.b);
        check_output({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~a; b = ~b; imm = ~imm;
        lat = 1;
        busy_cycles = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        check_output({v.name, " result"}, result, v.expected);
        check_output({v.name, " latency"}, 32'(lat), 32'(v.lat));
        check_output({v.name, " busy_cycles"}, 32'(busy_cycles), 32'(v.lat - 1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        add_vec("SUB",        R_TYPE, F3_ADD,    F7_ALT,  32'h0,        32'd5,        32'd7,        32'hFFFFFFFE, 1);
        add_vec("SRAI",       I_TYPE, F3_SRL,    F7_BASE, 32'h404,      32'h80000000, 32'h0,        32'hF8000000, 1);
        add_vec("SLTIU",      I_TYPE, F3_SLTU,   F7_BASE, 32'hFFFFFFFF, 32'd1,        32'h0,        32'd1,        1);
        add_vec("ADD",        R_TYPE, F3_ADD,    F7_BASE, 32'h0,        32'd2,        32'd3,        32'd5,        1);
        add_vec("SLL",        R_TYPE, F3_SLL,    F7_BASE, 32'h0,        32'd1,        32'h23,       32'd8,        1);
        add_vec("SLT",        R_TYPE, F3_SLT,    F7_BASE, 32'h0,        32'hFFFFFFFF, 32'd1,        32'd1,        1);
        add_vec("SLTU",       R_TYPE, F3_SLTU,   F7_BASE, 32'h0,        32'hFFFFFFFF, 32'd1,        32'd0,        1);
        add_vec("XOR",        R_TYPE, F3_XOR,    F7_BASE, 32'h0,        32'hF0F0,     32'h0FF0,     32'hFF00,     1);
        add_vec("SRL",        R_TYPE, F3_SRL,    F7_BASE, 32'h0,        32'h80000000, 32'd4,        32'h08000000, 1);
        add_vec("SRA",        R_TYPE, F3_SRL,    F7_ALT,  32'h0,        32'h80000000, 32'd4,        32'hF8000000, 1);
        add_vec("ORI",        I_TYPE, F3_OR,     F7_BASE, 32'hFFFFFFF0, 32'h0F,       32'h0,        32'hFFFFFFFF, 1);
        add_vec("AND",        R_TYPE, F3_AND,    F7_BASE, 32'h0,        32'hFF00,     32'h0FF0,     32'h0F00,     1);
        add_vec("ADDI",       I_TYPE, F3_ADD,    F7_ALT,  32'hFFFFFFFF, 32'd10,       32'd100,      32'd9,        1);
        add_vec("SRLI",       I_TYPE, F3_SRL,    F7_BASE, 32'd4,        32'h80000000, 32'h0,        32'h08000000, 1);
        add_vec("BAD_OPCODE", 7'h7F,  F3_ADD,    F7_BASE, 32'h0,        32'd2,        32'd3,        32'd0,        1);
        add_vec("BAD_FUNC7",  R_TYPE, F3_XOR,    F7_ALT,  32'h0,        32'hFF,       32'h0F,       32'd0,        1);
        add_vec("BAD_SLLI",   I_TYPE, F3_SLL,    F7_BASE, 32'h401,      32'd1,        32'h0,        32'd0,        1);
        add_vec("MUL",        R_TYPE, F3_MUL,    F7_MEXT, 32'h0,        32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, MUL_LAT);
        add_vec("MULH",       R_TYPE, F3_MULH,   F7_MEXT, 32'h0,        32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);
        add_vec("MULH_MIN",   R_TYPE, F3_MULH,   F7_MEXT, 32'h0,        32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        add_vec("MULHSU",     R_TYPE, F3_MULHSU, F7_MEXT, 32'h0,        32'h80000000, 32'h80000000, 32'hC0000000, MUL_LAT);
        add_vec("MULHU",      R_TYPE, F3_MULHU,  F7_MEXT, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        add_vec("DIV_ZERO",   R_TYPE, F3_DIV,    F7_MEXT, 32'h0,        32'd7,        32'd0,        32'hFFFFFFFF, DIV_LAT);
        add_vec("REM_ZERO",   R_TYPE, F3_REM,    F7_MEXT, 32'h0,        32'd7,        32'd0,        32'd7,        DIV_LAT);
        add_vec("DIV_OVF",    R_TYPE, F3_DIV,    F7_MEXT, 32'h0,        32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_LAT);
        add_vec("REM_OVF",    R_TYPE, F3_REM,    F7_MEXT, 32'h0,        32'h80000000, 32'hFFFFFFFF, 32'd0,        DIV_LAT);
        add_vec("DIV_NEG",    R_TYPE, F3_DIV,    F7_MEXT, 32'h0,        32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
        add_vec("REM_NEG",    R_TYPE, F3_REM,    F7_MEXT, 32'h0,        32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
        add_vec("DIV_NEGB",   R_TYPE, F3_DIV,    F7_MEXT, 32'h0,        32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, DIV_LAT);
        add_vec("REM_NEGB",   R_TYPE, F3_REM,    F7_MEXT, 32'h0,        32'd20,       32'hFFFFFFFD, 32'd2,        DIV_LAT);
        add_vec("DIVU",       R_TYPE, F3_DIVU,   F7_MEXT, 32'h0,        32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, DIV_LAT);
        add_vec("REMU",       R_TYPE, F3_REMU,   F7_MEXT, 32'h0,        32'hFFFFFFFF, 32'h10,       32'h0000000F, DIV_LAT);
        add_vec("DIVU_ZERO",  R_TYPE, F3_DIVU,   F7_MEXT, 32'h0,        32'd100,      32'd0,        32'hFFFFFFFF, DIV_LAT);
        add_vec("REMU_ZERO",  R_TYPE, F3_REMU,   F7_MEXT, 32'h0,        32'd100,      32'd0,        32'd100,      DIV_LAT);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset in_ready", 32'(in_ready), 32'd1);
        check_output("reset result", result, 32'd0);

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Backpressure: hold DONE for 10 cycles, then drain and issue in the same cycle.
        @(negedge clk);
        drive(R_TYPE, F3_ADD, F7_BASE, 32'h0, 32'd1, 32'd1);
        @(posedge clk);
        #1;
        drive(R_TYPE, F3_ADD, F7_ALT, 32'h0, 32'd9, 32'd4);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check_output($sformatf("hold%0d result", i), result, 32'd2);
            check_output($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
            check_output($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check_output("b2b in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check_output("b2b out_valid", 32'(out_valid), 32'd1);
        check_output("b2b result", result, 32'd5);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_output("b2b drained", 32'(out_valid), 32'd0);

        // Reset in the middle of a DIVU aborts it.
        drive(R_TYPE, F3_DIVU, F7_MEXT, 32'h0, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check_output("divu busy before reset", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("abort out_valid", 32'(out_valid), 32'd0);
        check_output("abort busy", 32'(busy), 32'd0);
        check_output("abort in_ready", 32'(in_ready), 32'd1);
        check_output("abort result", result, 32'd0);
        apply_stimulus(vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
